// File: rtl/mbist_pkg.sv
// Shared March C- definitions: element encoding, per-element op table,
// sequencer FSM states and data backgrounds.
package mbist_pkg;

  typedef enum logic [2:0] {
    E0 = 3'd0, E1 = 3'd1, E2 = 3'd2, E3 = 3'd3, E4 = 3'd4, E5 = 3'd5
  } elem_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  // Backgrounds are replicated across the data width: D0 = all-zeros, D1 = all-ones.
  localparam logic BG_D0 = 1'b0;
  localparam logic BG_D1 = 1'b1;

  function automatic logic elem_up(elem_e e);
    return (e == E0) || (e == E1) || (e == E2);
  endfunction

  function automatic logic elem_two_ops(elem_e e);
    return (e != E0) && (e != E5);
  endfunction

  function automatic logic op_is_write(elem_e e, logic opi);
    case (e)
      E0:      return 1'b1;
      E5:      return 1'b0;
      default: return opi;
    endcase
  endfunction

  // E1/E3 are (r0,w1), E2/E4 are (r1,w0); E0 is w0 and E5 is r0.
  function automatic logic op_bg(elem_e e, logic opi);
    case (e)
      E1, E3:  return opi ? BG_D1 : BG_D0;
      E2, E4:  return opi ? BG_D0 : BG_D1;
      default: return BG_D0;
    endcase
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for one March element; direction is latched on load.
module march_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              load,
  input  logic              load_up,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic up;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      addr <= '0;
      up   <= 1'b1;
    end else if (load) begin
      addr <= load_up ? '0 : '1;
      up   <= load_up;
    end else if (step) begin
      addr <= up ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
    end
  end

  assign last = up ? (addr == '1) : (addr == '0);

endmodule

// File: rtl/march_ctrl.sv
// March C- MBIST sequencer: drives the SRAM, attributes delayed comparator
// results to (address, element) and logs pass/fail.
module march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int CMP_LAT = 2,
  parameter int FCNT_W  = 8
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              START,
  input  logic              STOP_ON_FAIL,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [2:0]        FAIL_ELEM,
  output logic [FCNT_W-1:0] FAIL_COUNT,
  output logic              MEM_CE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [DATA_W-1:0] ExpDATA,
  input  logic              RESULT,
  output logic [1:0]        DBG_STATE
);

  localparam int DCW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  state_e            state, state_n;
  elem_e             elem, elem_n;
  logic              opi, opi_n;
  logic              stop_r, accept;
  logic [DCW-1:0]    drain_cnt;
  logic              gen_load, gen_load_up, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_addr;
  logic              is_write, op_last, wr_issue, rd_issue, mismatch;
  logic [DATA_W-1:0] data_val, wdata_q, exp_q;

  logic              pv [CMP_LAT];
  logic [ADDR_W-1:0] pa [CMP_LAT];
  elem_e             pe [CMP_LAT];

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .load    (gen_load),
    .load_up (gen_load_up),
    .step    (gen_step),
    .addr    (gen_addr),
    .last    (gen_last)
  );

  assign is_write = op_is_write(elem, opi);
  assign op_last  = elem_two_ops(elem) ? opi : 1'b1;
  assign data_val = {DATA_W{op_bg(elem, opi)}};
  assign wr_issue = (state == S_RUN) && is_write;
  assign rd_issue = (state == S_RUN) && !is_write;
  // A read shown in cycle t has its RESULT in cycle t+CMP_LAT, when its entry sits in pv[CMP_LAT-1].
  assign mismatch = pv[CMP_LAT-1] && !RESULT;

  always_comb begin
    state_n     = state;
    elem_n      = elem;
    opi_n       = opi;
    gen_load    = 1'b0;
    gen_load_up = 1'b1;
    gen_step    = 1'b0;
    accept      = 1'b0;
    case (state)
      S_IDLE, S_FIN: begin
        if (START) begin
          state_n  = S_RUN;
          elem_n   = E0;
          opi_n    = 1'b0;
          gen_load = 1'b1;
          accept   = 1'b1;
        end
      end
      S_RUN: begin
        if (mismatch && stop_r) begin
          state_n = S_DRAIN;
        end else if (!op_last) begin
          opi_n = 1'b1;
        end else if (!gen_last) begin
          opi_n    = 1'b0;
          gen_step = 1'b1;
        end else if (elem == E5) begin
          state_n = S_DRAIN;
        end else begin
          elem_n      = elem_e'(elem + 3'd1);
          opi_n       = 1'b0;
          gen_load    = 1'b1;
          gen_load_up = elem_up(elem_e'(elem + 3'd1));
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DCW'(CMP_LAT - 1)) state_n = S_FIN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      elem      <= E0;
      opi       <= 1'b0;
      drain_cnt <= '0;
      wdata_q   <= '0;
      exp_q     <= '0;
    end else begin
      state     <= state_n;
      elem      <= elem_n;
      opi       <= opi_n;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (wr_issue) wdata_q <= data_val;
      if (rd_issue) exp_q <= data_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      for (int i = 0; i < CMP_LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pe[i] <= E0;
      end
    end else begin
      pv[0] <= rd_issue;
      pa[0] <= gen_addr;
      pe[0] <= elem;
      for (int i = 1; i < CMP_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      FAIL       <= 1'b0;
      FAIL_ADDR  <= '0;
      FAIL_ELEM  <= '0;
      FAIL_COUNT <= '0;
      stop_r     <= 1'b0;
    end else if (accept) begin
      FAIL       <= 1'b0;
      FAIL_ADDR  <= '0;
      FAIL_ELEM  <= '0;
      FAIL_COUNT <= '0;
      stop_r     <= STOP_ON_FAIL;
    end else if (mismatch) begin
      if (!FAIL) begin
        FAIL      <= 1'b1;
        FAIL_ADDR <= pa[CMP_LAT-1];
        FAIL_ELEM <= pe[CMP_LAT-1];
      end
      if (FAIL_COUNT != '1) FAIL_COUNT <= FAIL_COUNT + FCNT_W'(1);
    end
  end

  assign BUSY      = (state == S_RUN) || (state == S_DRAIN);
  assign DONE      = (state == S_FIN);
  assign MEM_CE    = (state == S_RUN);
  assign MEM_WE    = wr_issue;
  assign MEM_ADDR  = gen_addr;
  assign MEM_WDATA = wr_issue ? data_val : wdata_q;
  assign ExpDATA   = rd_issue ? data_val : exp_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_march_ctrl.sv
// Bench for march_ctrl: SRAM + 2-cycle comparator model, directed runs,
// scoreboard queues checked by monitors on access cycles and DONE rise.
module tb_march_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRESET = 1'b0, START = 1'b0, STOP_ON_FAIL = 1'b0;
  logic       fault_en = 1'b0, sat_en = 1'b0, start2;
  logic       RESULT;
  logic       BUSY, DONE, FAIL, MEM_CE, MEM_WE;
  logic [3:0] FAIL_ADDR, MEM_ADDR;
  logic [2:0] FAIL_ELEM;
  logic [7:0] FAIL_COUNT, MEM_WDATA, ExpDATA;
  logic [1:0] DBG_STATE;

  logic       BUSY2, DONE2, FAIL2, MEM_CE2, MEM_WE2;
  logic [3:0] FAIL_ADDR2, MEM_ADDR2, FAIL_COUNT2;
  logic [2:0] FAIL_ELEM2;
  logic [7:0] MEM_WDATA2, ExpDATA2;
  logic [1:0] DBG_STATE2;

  assign start2 = START & sat_en;

  march_ctrl #(.ADDR_W(4), .DATA_W(8), .CMP_LAT(2), .FCNT_W(8)) dut (
    .CLK(CLK), .nRESET(nRESET), .START(START), .STOP_ON_FAIL(STOP_ON_FAIL),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR),
    .FAIL_ELEM(FAIL_ELEM), .FAIL_COUNT(FAIL_COUNT), .MEM_CE(MEM_CE),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .ExpDATA(ExpDATA), .RESULT(RESULT), .DBG_STATE(DBG_STATE)
  );

  // Comparator that mismatches on every read: all addresses faulty.
  march_ctrl #(.ADDR_W(4), .DATA_W(8), .CMP_LAT(2), .FCNT_W(4)) dut_sat (
    .CLK(CLK), .nRESET(nRESET), .START(start2), .STOP_ON_FAIL(STOP_ON_FAIL),
    .BUSY(BUSY2), .DONE(DONE2), .FAIL(FAIL2), .FAIL_ADDR(FAIL_ADDR2),
    .FAIL_ELEM(FAIL_ELEM2), .FAIL_COUNT(FAIL_COUNT2), .MEM_CE(MEM_CE2),
    .MEM_WE(MEM_WE2), .MEM_ADDR(MEM_ADDR2), .MEM_WDATA(MEM_WDATA2),
    .ExpDATA(ExpDATA2), .RESULT(1'b0), .DBG_STATE(DBG_STATE2)
  );

  // SRAM with optional stuck-at-0 on bit 3 of address 5, plus 2-stage comparator.
  logic [7:0] mem [16];
  logic [7:0] rd;
  logic       c0 = 1'b0, c1 = 1'b0;
  always_comb rd = (fault_en && MEM_ADDR == 4'd5) ? (mem[MEM_ADDR] & 8'hF7) : mem[MEM_ADDR];
  always @(posedge CLK) begin
    if (MEM_CE && MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    c0 <= MEM_CE && !MEM_WE && (rd == ExpDATA);
    c1 <= c0;
  end
  assign RESULT = c1;

  int n_checks = 0, n_fail = 0;
  logic [12:0] trace_q[$];
  logic [31:0] res_q[$], res2_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_res(logic f, logic [3:0] fa, logic [2:0] fe,
                                           logic [7:0] fc, logic [7:0] bl, logic [7:0] ce);
    return {f, fa, fe, fc, bl, ce};
  endfunction

  task automatic check_res(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check({tag, "_fail"},       act[31],    exp[31]);
    check({tag, "_fail_addr"},  act[30:27], exp[30:27]);
    check({tag, "_fail_elem"},  act[26:24], exp[26:24]);
    check({tag, "_fail_count"}, act[23:16], exp[23:16]);
    check({tag, "_busy_len"},   act[15:8],  exp[15:8]);
    check({tag, "_ce_cycles"},  act[7:0],   exp[7:0]);
  endtask

  // Monitor for the main instance: access trace and end-of-run results.
  logic busy_d = 1'b0, done_d = 1'b0;
  int   busy_len = 0, ce_cnt = 0;
  always @(negedge CLK) begin
    if (BUSY && !busy_d) begin busy_len = 0; ce_cnt = 0; end
    if (BUSY) busy_len++;
    if (MEM_CE) begin
      ce_cnt++;
      if (trace_q.size() > 0)
        check("trace", {MEM_WE, MEM_ADDR, MEM_WE ? MEM_WDATA : ExpDATA}, trace_q.pop_front());
    end
    if (DONE && !done_d) begin
      if (res_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got DONE=1 expected no DONE");
      end else begin
        check_res("run", pack_res(FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_COUNT, 8'(busy_len), 8'(ce_cnt)),
                  res_q.pop_front());
      end
    end
    busy_d = BUSY;
    done_d = DONE;
  end

  logic busy2_d = 1'b0, done2_d = 1'b0;
  int   busy2_len = 0, ce2_cnt = 0;
  always @(negedge CLK) begin
    if (BUSY2 && !busy2_d) begin busy2_len = 0; ce2_cnt = 0; end
    if (BUSY2) busy2_len++;
    if (MEM_CE2) ce2_cnt++;
    if (DONE2 && !done2_d) begin
      if (res2_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done_sat: got DONE=1 expected no DONE");
      end else begin
        check_res("sat", pack_res(FAIL2, FAIL_ADDR2, FAIL_ELEM2, {4'h0, FAIL_COUNT2},
                                  8'(busy2_len), 8'(ce2_cnt)), res2_q.pop_front());
      end
    end
    busy2_d = BUSY2;
    done2_d = DONE2;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!DONE && k < 1000) begin
      @(negedge CLK);
      k++;
    end
    if (!DONE) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got DONE=0 expected 1", tag);
    end
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       BUSY,       0);
    check({tag, "_done"},       DONE,       0);
    check({tag, "_fail"},       FAIL,       0);
    check({tag, "_mem_ce"},     MEM_CE,     0);
    check({tag, "_mem_we"},     MEM_WE,     0);
    check({tag, "_fail_addr"},  FAIL_ADDR,  0);
    check({tag, "_fail_elem"},  FAIL_ELEM,  0);
    check({tag, "_fail_count"}, FAIL_COUNT, 0);
    check({tag, "_mem_addr"},   MEM_ADDR,   0);
    check({tag, "_mem_wdata"},  MEM_WDATA,  0);
    check({tag, "_expdata"},    ExpDATA,    0);
    check({tag, "_state"},      DBG_STATE,  0);
  endtask

  // Expected March C- access sequence: {we, addr, wdata-or-expected}.
  task automatic push_trace();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] a;
        a = (e < 3) ? i[3:0] : 4'(15 - i);
        trace_q.push_back({(e == 0), a, (e == 2 || e == 4) ? 8'hFF : 8'h00});
        if (e > 0 && e < 5)
          trace_q.push_back({1'b1, a, (e == 1 || e == 3) ? 8'hFF : 8'h00});
      end
    end
  endtask

  initial begin
    tick(3);
    check_reset_outputs("por");
    nRESET = 1'b1;
    tick(2);

    // Fault-free run with full access trace.
    push_trace();
    res_q.push_back(pack_res(1'b0, 4'd0, 3'd0, 8'd0, 8'd162, 8'd160));
    pulse_start();
    wait_done("clean");

    // Stuck-at-0 bit 3 @5: fails in E2 r1 and E4 r1.
    fault_en = 1'b1;
    res_q.push_back(pack_res(1'b1, 4'd5, 3'd2, 8'd2, 8'd162, 8'd160));
    pulse_start();
    wait_done("fault");

    // Same fault, abort on first mismatch: read @5 in E2 at cycle 58, sampled at 60.
    STOP_ON_FAIL = 1'b1;
    res_q.push_back(pack_res(1'b1, 4'd5, 3'd2, 8'd1, 8'd63, 8'd61));
    pulse_start();
    STOP_ON_FAIL = 1'b0;
    wait_done("stop");
    fault_en = 1'b0;

    // Reset mid-run: outputs return to reset values and no DONE follows.
    pulse_start();
    tick(49);
    nRESET = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    check_reset_outputs("midrst");
    tick(200);
    check("midrst_no_done", DONE, 0);
    res_q.push_back(pack_res(1'b0, 4'd0, 3'd0, 8'd0, 8'd162, 8'd160));
    pulse_start();
    wait_done("after_rst");

    // START while busy is ignored.
    res_q.push_back(pack_res(1'b0, 4'd0, 3'd0, 8'd0, 8'd162, 8'd160));
    pulse_start();
    tick(19);
    pulse_start();
    wait_done("restart");

    // Every read fails on the 4-bit-counter instance: saturates at 15.
    sat_en = 1'b1;
    res_q.push_back(pack_res(1'b0, 4'd0, 3'd0, 8'd0, 8'd162, 8'd160));
    res2_q.push_back(pack_res(1'b1, 4'd0, 3'd1, 8'd15, 8'd162, 8'd160));
    pulse_start();
    sat_en = 1'b0;
    wait_done("sat");
    tick(2);

    check("trace_q_empty", trace_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    check("res2_q_empty", res2_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
